acq_sequence_controller: RTL
============================

// Module: acq_sequence_controller
// PURPOSE
//  Sequences repeated ADC capture bursts. Each burst resets the capture block, fires one trigger,
//  waits for capture-complete, then holds off until the next pulse-repetition slot. Alternates the
//  RAM bank (ping-pong) between bursts, counts bursts, and flags timeout and overrun conditions.
//  Sits between the host register file and the ADC capture block (trigger/state-reset/record-length/done).
// PARAMETERS
//  CAP_RESET_CYCLES  4   cycles oCapReset is held high before each trigger (>=1)
//  PRI_W             24  width of repetition-interval and timeout counters
//  CNT_W             16  width of burst count / index
// PORTS
//  adc_clkinp    in   1      sole clock, rising edge
//  iStateReset   in   1      asynchronous, active-high reset
//  iStart        in   1      1-cycle start pulse; ignored while oBusy=1
//  iAbort        in   1      level; abort from any non-IDLE state
//  iNumAcqs      in   CNT_W  bursts to run; latched on accepted iStart
//  iPRI          in   PRI_W  min cycles trigger-to-trigger; latched on iStart
//  iTimeout      in   PRI_W  max cycles trigger-to-done; 0 = no timeout; latched on iStart
//  iRecLength    in   16     samples per burst; latched on iStart
//  iRcvDone      in   1      capture-complete level from capture block (held until its reset)
//  oSystemTrig   out  1      1-cycle trigger pulse to capture block
//  oCapReset     out  1      state reset to capture block
//  oRecLength    out  16     latched record length
//  oBankSel      out  1      RAM bank for current burst
//  oAcqIndex     out  CNT_W  index of current/last burst (0-based)
//  oBusy         out  1      high from accepted start until IDLE
//  oDone         out  1      1-cycle pulse at normal completion or timeout
//  oTimeoutErr   out  1      sticky; cleared on accepted iStart
//  oOverrun      out  1      sticky; capture took longer than PRI; cleared on accepted iStart
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, done-edge register 0.
//  States: IDLE -> ARM -> HOLD -> TRIG -> WAIT -> (ARM | DONE); ABORT -> IDLE.
//  IDLE: iStart latches config, clears sticky flags, oAcqIndex=0, oBankSel=0 -> ARM next cycle.
//    iNumAcqs==0 (macro absent): go DONE directly, no trigger issued.
//  ARM: oCapReset=1 for exactly CAP_RESET_CYCLES cycles, then HOLD; clears capture done level.
//  HOLD: wait until pri_cnt >= iPRI-1 (first burst: immediate) -> TRIG. If condition already true on
//    entry for a non-first burst, set oOverrun.
//  TRIG: oSystemTrig=1 for this cycle only; pri_cnt and to_cnt cleared to 0 here -> WAIT.
//    Result: consecutive triggers exactly max(iPRI, actual burst time) cycles apart.
//  pri_cnt: increments every cycle outside TRIG, saturates at all-ones.
//  WAIT: rising edge of iRcvDone (registered edge detect) -> if oAcqIndex==iNumAcqs-1 -> DONE,
//    else oAcqIndex+=1, oBankSel toggles, -> ARM (same cycle update).
//    to_cnt increments; iTimeout!=0 and to_cnt==iTimeout-1 without done -> oTimeoutErr=1 -> DONE.
//    Done edge and timeout in same cycle: done wins, no error.
//  DONE: oDone=1 one cycle, oCapReset=0, -> IDLE; oBusy falls entering IDLE.
//  iAbort (any non-IDLE state, priority over all): -> ABORT: oCapReset=1 one cycle, no oDone,
//    oAcqIndex/oBankSel hold -> IDLE. iAbort in IDLE ignored; iStart+iAbort same cycle in IDLE: start.
//  Async reset mid-burst: immediate return to reset values; capture block left to its own reset.
//  oRecLength stable for whole run; changes only on accepted iStart.
// CONFIGURATION
//  ACQ_CONTINUOUS_EN defined: iNumAcqs==0 means run indefinitely; oAcqIndex wraps modulo 2^CNT_W,
//    bank keeps toggling; terminates only via iAbort or timeout.
//  ACQ_CONTINUOUS_EN undefined: iNumAcqs==0 completes immediately as above.
// TESTING
//  1 burst: iNumAcqs=1,iPRI=100,iTimeout=0, done 20 cyc after trig -> 4 cyc oCapReset, 1 trig, oDone, bank=0.
//  3 bursts: iPRI=100, done 30 cyc after each trig -> triggers exactly 100 cyc apart, bank 0,1,0, oOverrun=0.
//  Overrun: iPRI=10, done 50 cyc after trig -> triggers 50+CAP_RESET_CYCLES+2 apart, oOverrun=1.
//  Timeout: iTimeout=64, iRcvDone never -> oTimeoutErr=1, oDone pulse 64 cyc after trig.
//  Abort in WAIT of burst 2 -> 1 cyc oCapReset, oBusy=0 in 2 cyc, no oDone, oAcqIndex=1.
//  iNumAcqs=0: macro off -> oDone, no trig; ACQ_CONTINUOUS_EN -> runs >5 bursts until iAbort.

Source files
------------

// File: rtl/acq_sequence_controller_if.sv
// Host/capture-side bundle for acq_sequence_controller.
// Ports: i* command/config/status inputs, o* trigger/reset/status outputs.
interface acq_sequence_controller_if #(
    parameter int PRI_W = 24,
    parameter int CNT_W = 16
);
    logic             iStart;
    logic             iAbort;
    logic [CNT_W-1:0] iNumAcqs;
    logic [PRI_W-1:0] iPRI;
    logic [PRI_W-1:0] iTimeout;
    logic [15:0]      iRecLength;
    logic             iRcvDone;
    logic             oSystemTrig;
    logic             oCapReset;
    logic [15:0]      oRecLength;
    logic             oBankSel;
    logic [CNT_W-1:0] oAcqIndex;
    logic             oBusy;
    logic             oDone;
    logic             oTimeoutErr;
    logic             oOverrun;

    // controller side
    modport slave (
        input  iStart, iAbort, iNumAcqs, iPRI, iTimeout,
        input  iRecLength, iRcvDone,
        output oSystemTrig, oCapReset, oRecLength, oBankSel,
        output oAcqIndex, oBusy, oDone, oTimeoutErr, oOverrun
    );

    // host register file / capture block side
    modport master (
        output iStart, iAbort, iNumAcqs, iPRI, iTimeout,
        output iRecLength, iRcvDone,
        input  oSystemTrig, oCapReset, oRecLength, oBankSel,
        input  oAcqIndex, oBusy, oDone, oTimeoutErr, oOverrun
    );
endinterface

// File: rtl/acq_sequence_controller.sv
// Sequences ADC capture bursts: cap reset, trigger, wait done, PRI holdoff,
// ping-pong bank, burst index, timeout/overrun flags.
// Ports: adc_clkinp (clock), iStateReset (async, active high),
// bus (acq_sequence_controller_if.slave).
// Option: ACQ_CONTINUOUS_EN makes iNumAcqs==0 run until abort/timeout.
module acq_sequence_controller #(
    parameter int CAP_RESET_CYCLES = 4,
    parameter int PRI_W            = 24,
    parameter int CNT_W            = 16
) (
    input logic                      adc_clkinp,
    input logic                      iStateReset,
    acq_sequence_controller_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_HOLD, S_TRIG, S_WAIT, S_DONE, S_ABORT
    } state_e;

    localparam int CAP_W =
        (CAP_RESET_CYCLES > 1) ? $clog2(CAP_RESET_CYCLES) : 1;
    localparam logic [CAP_W-1:0] CAP_LAST = CAP_W'(CAP_RESET_CYCLES - 1);
    localparam logic [PRI_W-1:0] PRI_ONE  = {{(PRI_W-1){1'b0}}, 1'b1};
    localparam logic [PRI_W-1:0] PRI_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [PRI_W-1:0] pri_q, pri_d;
    logic [PRI_W-1:0] tmo_q, tmo_d;
    logic [15:0]      rec_len_q, rec_len_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             bank_q, bank_d;
    logic             tmo_err_q, tmo_err_d;
    logic             ovr_q, ovr_d;
    logic [CAP_W-1:0] cap_cnt_q, cap_cnt_d;
    logic [PRI_W-1:0] pri_cnt_q, pri_cnt_d;
    logic [PRI_W-1:0] to_cnt_q, to_cnt_d;
    logic             rcv_q, rcv_d;
    logic             first_q, first_d;
    logic             hold_new_q, hold_new_d;

    logic             rcv_edge;
    logic             pri_ok;
    logic             last_acq;
    logic             to_hit;
    logic [PRI_W:0]   pri_cnt_x;

    always_ff @(posedge adc_clkinp or posedge iStateReset) begin
        if (iStateReset) begin
            state_q    <= S_IDLE;
            num_q      <= '0;
            pri_q      <= '0;
            tmo_q      <= '0;
            rec_len_q  <= '0;
            idx_q      <= '0;
            bank_q     <= 1'b0;
            tmo_err_q  <= 1'b0;
            ovr_q      <= 1'b0;
            cap_cnt_q  <= '0;
            pri_cnt_q  <= '0;
            to_cnt_q   <= '0;
            rcv_q      <= 1'b0;
            first_q    <= 1'b0;
            hold_new_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            pri_q      <= pri_d;
            tmo_q      <= tmo_d;
            rec_len_q  <= rec_len_d;
            idx_q      <= idx_d;
            bank_q     <= bank_d;
            tmo_err_q  <= tmo_err_d;
            ovr_q      <= ovr_d;
            cap_cnt_q  <= cap_cnt_d;
            pri_cnt_q  <= pri_cnt_d;
            to_cnt_q   <= to_cnt_d;
            rcv_q      <= rcv_d;
            first_q    <= first_d;
            hold_new_q <= hold_new_d;
        end
    end

    assign rcv_edge  = bus.iRcvDone & ~rcv_q;
    // counters are zero in the trigger cycle, so pri_cnt+1 is the
    // trigger-to-trigger distance if we fire next cycle
    assign pri_cnt_x = {1'b0, pri_cnt_q} + {{PRI_W{1'b0}}, 1'b1};
    assign pri_ok    = first_q || (pri_cnt_x >= {1'b0, pri_q});
    assign to_hit    = (tmo_q != '0) && (to_cnt_q == tmo_q - PRI_ONE);
`ifdef ACQ_CONTINUOUS_EN
    assign last_acq  = (num_q != '0) && (idx_q == num_q - CNT_ONE);
`else
    assign last_acq  = (idx_q == num_q - CNT_ONE);
`endif

    always_comb begin : next_state
        state_d    = state_q;
        num_d      = num_q;
        pri_d      = pri_q;
        tmo_d      = tmo_q;
        rec_len_d  = rec_len_q;
        idx_d      = idx_q;
        bank_d     = bank_q;
        tmo_err_d  = tmo_err_q;
        ovr_d      = ovr_q;
        cap_cnt_d  = '0;
        first_d    = first_q;
        hold_new_d = 1'b0;
        rcv_d      = bus.iRcvDone;
        pri_cnt_d  = (pri_cnt_q == PRI_MAX) ? pri_cnt_q : pri_cnt_q + PRI_ONE;
        to_cnt_d   = (to_cnt_q == PRI_MAX) ? to_cnt_q : to_cnt_q + PRI_ONE;

        unique case (state_q)
            S_IDLE: begin
                if (bus.iStart) begin
                    num_d     = bus.iNumAcqs;
                    pri_d     = bus.iPRI;
                    tmo_d     = bus.iTimeout;
                    rec_len_d = bus.iRecLength;
                    idx_d     = '0;
                    bank_d    = 1'b0;
                    tmo_err_d = 1'b0;
                    ovr_d     = 1'b0;
                    first_d   = 1'b1;
`ifdef ACQ_CONTINUOUS_EN
                    state_d   = S_ARM;
`else
                    state_d   = (bus.iNumAcqs == '0) ? S_DONE : S_ARM;
`endif
                end
            end
            S_ARM: begin
                cap_cnt_d = cap_cnt_q + 1'b1;
                if (cap_cnt_q == CAP_LAST) begin
                    cap_cnt_d  = '0;
                    hold_new_d = 1'b1;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (pri_ok) begin
                    // already due on the first HOLD cycle: capture outran PRI
                    if (hold_new_q && !first_q) ovr_d = 1'b1;
                    state_d = S_TRIG;
                end
            end
            S_TRIG: begin
                first_d = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rcv_edge) begin
                    if (last_acq) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + CNT_ONE;
                        bank_d  = ~bank_q;
                        state_d = S_ARM;
                    end
                end else if (to_hit) begin
                    tmo_err_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // abort overrides whatever the state decided, keeping index/bank/flags
        if (bus.iAbort && state_q != S_IDLE && state_q != S_ABORT) begin
            state_d    = S_ABORT;
            idx_d      = idx_q;
            bank_d     = bank_q;
            tmo_err_d  = tmo_err_q;
            ovr_d      = ovr_q;
            cap_cnt_d  = '0;
            hold_new_d = 1'b0;
        end

        if (state_d == S_TRIG) begin
            pri_cnt_d = '0;
            to_cnt_d  = '0;
        end
    end

    always_comb begin : outputs
        bus.oSystemTrig = (state_q == S_TRIG);
        bus.oCapReset   = (state_q == S_ARM) || (state_q == S_ABORT);
        bus.oBusy       = (state_q != S_IDLE);
        bus.oDone       = (state_q == S_DONE);
        bus.oRecLength  = rec_len_q;
        bus.oBankSel    = bank_q;
        bus.oAcqIndex   = idx_q;
        bus.oTimeoutErr = tmo_err_q;
        bus.oOverrun    = ovr_q;
    end
endmodule
